// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave endpoint and the benches that pair it
// with spi_master.
//   SPI_TRF_BIT_DEFAULT : default frame length in bits
//   spi_slave_state_t   : slave frame-tracking states
//   spi_cnt_width()     : width of a counter that must hold 0..trf_bit
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_TRF_BIT_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } spi_slave_state_t;

  // The bit counter must reach trf_bit itself without wrapping.
  function automatic int spi_cnt_width(input int trf_bit);
    return $clog2(trf_bit + 1);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// ---------------------------------------------------------------------------
// spi_pin_sync
// Brings the asynchronous SPI pins into the clk domain and produces
// registered one-cycle edge pulses.
//   clk, rst   : system clock, synchronous active-high reset
//   sclk, cs   : raw SPI clock / chip select pins
//   mosi       : raw serial data pin
//   s_mosi     : mosi after one register stage
//   s_cs       : cs after one register stage
//   sclk_rise  : pulse, sclk went low->high
//   sclk_fall  : pulse, sclk went high->low
//   cs_fall    : pulse, cs asserted (high->low)
//   cs_rise    : pulse, cs released (low->high)
// The edge pulses are registered, so an event sampled at edge k is presented
// to downstream logic during the cycle that ends at edge k+2.
// ---------------------------------------------------------------------------
module spi_pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic s_mosi,
  output logic s_cs,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic s_sclk_r;
  logic s_cs_r;
  logic s_mosi_r;
  logic p_sclk_r;
  logic p_cs_r;
  logic sclk_rise_r;
  logic sclk_fall_r;
  logic cs_fall_r;
  logic cs_rise_r;

  logic sclk_rise_s;
  logic sclk_fall_s;
  logic cs_fall_s;
  logic cs_rise_s;

  // Edge decode between the first and second register stages.
  always_comb begin
    sclk_rise_s = ~p_sclk_r & s_sclk_r;
    sclk_fall_s = p_sclk_r & ~s_sclk_r;
    cs_fall_s   = p_cs_r & ~s_cs_r;
    cs_rise_s   = ~p_cs_r & s_cs_r;
  end

  // Pin sampling registers and edge pulse registers. Resetting the cs stages
  // low means a cs already low at reset release never looks like a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_sclk_r    <= 1'b0;
      s_cs_r      <= 1'b0;
      s_mosi_r    <= 1'b0;
      p_sclk_r    <= 1'b0;
      p_cs_r      <= 1'b0;
      sclk_rise_r <= 1'b0;
      sclk_fall_r <= 1'b0;
      cs_fall_r   <= 1'b0;
      cs_rise_r   <= 1'b0;
    end else begin
      s_sclk_r    <= sclk;
      s_cs_r      <= cs;
      s_mosi_r    <= mosi;
      p_sclk_r    <= s_sclk_r;
      p_cs_r      <= s_cs_r;
      sclk_rise_r <= sclk_rise_s;
      sclk_fall_r <= sclk_fall_s;
      cs_fall_r   <= cs_fall_s;
      cs_rise_r   <= cs_rise_s;
    end
  end

  assign s_mosi    = s_mosi_r;
  assign s_cs      = s_cs_r;
  assign sclk_rise = sclk_rise_r;
  assign sclk_fall = sclk_fall_r;
  assign cs_fall   = cs_fall_r;
  assign cs_rise   = cs_rise_r;

endmodule

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// SPI slave endpoint (sclk idle low, MSB first). Receives one word on mosi
// and returns one preloaded response word on miso in the same frame.
//   clk, rst    : system clock, synchronous active-high reset
//   sclk, cs    : SPI clock (idle low) and chip select (active low)
//   mosi, miso  : serial data in / out (miso is 0 outside a frame)
//   tx_data     : response word, written when tx_load is high
//   tx_load     : response buffer write strobe (last write wins)
//   tx_pending  : the response buffer holds an unsent word
//   rx_data     : last complete received word
//   rx_valid    : one-cycle pulse when rx_data updates
//   frame_err   : one-cycle pulse when cs releases mid-word
//   busy        : a frame is in progress (ACTIVE or DONE)
// ---------------------------------------------------------------------------
module spi_slave
  import spi_pkg::*;
#(
  parameter int SPI_TRF_BIT = SPI_TRF_BIT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sclk,
  input  logic                   cs,
  input  logic                   mosi,
  output logic                   miso,
  input  logic [SPI_TRF_BIT-1:0] tx_data,
  input  logic                   tx_load,
  output logic                   tx_pending,
  output logic [SPI_TRF_BIT-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int                   CNT_W    = spi_cnt_width(SPI_TRF_BIT);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(SPI_TRF_BIT - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [SPI_TRF_BIT-1:0] ZERO_WORD = {SPI_TRF_BIT{1'b0}};

  logic s_mosi;
  logic s_cs;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  spi_slave_state_t       state_r,      state_s;
  logic [SPI_TRF_BIT-1:0] shift_out_r,  shift_out_s;
  logic [SPI_TRF_BIT-2:0] shift_in_r,   shift_in_s;
  logic [CNT_W-1:0]       bit_cnt_r,    bit_cnt_s;
  logic                   miso_r,       miso_s;
  logic [SPI_TRF_BIT-1:0] rx_data_r,    rx_data_s;
  logic                   rx_valid_r,   rx_valid_s;
  logic                   frame_err_r,  frame_err_s;
  logic [SPI_TRF_BIT-1:0] tx_buf_r,     tx_buf_s;
  logic                   tx_pending_r, tx_pending_s;
  logic                   busy_r;
  logic [SPI_TRF_BIT-1:0] rx_word_s;

  spi_pin_sync u_pin_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .s_mosi    (s_mosi),
    .s_cs      (s_cs),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  // Word as it stands once the bit arriving on this sclk fall is included.
  assign rx_word_s = {shift_in_r, s_mosi};

  // Next-state and datapath update for the frame FSM and response buffer.
  always_comb begin
    state_s      = state_r;
    shift_out_s  = shift_out_r;
    shift_in_s   = shift_in_r;
    bit_cnt_s    = bit_cnt_r;
    miso_s       = miso_r;
    rx_data_s    = rx_data_r;
    rx_valid_s   = 1'b0;
    frame_err_s  = 1'b0;
    tx_buf_s     = tx_buf_r;
    tx_pending_s = tx_pending_r;

    case (state_r)
      IDLE: begin
        miso_s = 1'b0;
        // A cs that has already gone high again by now was only a glitch.
        if (cs_fall && !s_cs) begin
          shift_out_s  = tx_pending_r ? tx_buf_r : ZERO_WORD;
          tx_pending_s = 1'b0;
          shift_in_s   = ZERO_WORD[SPI_TRF_BIT-2:0];
          bit_cnt_s    = {CNT_W{1'b0}};
          state_s      = ACTIVE;
        end else begin
          state_s = IDLE;
        end
      end

      ACTIVE: begin
        // The final sclk fall completes the word even if cs releases in the
        // same cycle; any other cs release aborts the frame.
        if (sclk_fall) begin
          shift_in_s = rx_word_s[SPI_TRF_BIT-2:0];
          bit_cnt_s  = bit_cnt_r + CNT_ONE;
          if (bit_cnt_r == LAST_BIT) begin
            rx_data_s  = rx_word_s;
            rx_valid_s = 1'b1;
            miso_s     = 1'b0;
            state_s    = cs_rise ? IDLE : DONE;
          end else if (cs_rise) begin
            frame_err_s = 1'b1;
            miso_s      = 1'b0;
            state_s     = IDLE;
          end else begin
            state_s = ACTIVE;
          end
        end else if (cs_rise) begin
          frame_err_s = 1'b1;
          miso_s      = 1'b0;
          state_s     = IDLE;
        end else if (sclk_rise) begin
          // Present the next bit on the rising edge so it is stable when the
          // master samples on the following falling edge.
          miso_s      = shift_out_r[SPI_TRF_BIT-1];
          shift_out_s = {shift_out_r[SPI_TRF_BIT-2:0], 1'b0};
        end else begin
          state_s = ACTIVE;
        end
      end

      DONE: begin
        miso_s = 1'b0;
        if (cs_rise) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end

      default: begin
        miso_s  = 1'b0;
        state_s = IDLE;
      end
    endcase

    // Applied after the frame start so a load racing a cs fall stays pending
    // for the next frame instead of being consumed by this one.
    if (tx_load) begin
      tx_buf_s     = tx_data;
      tx_pending_s = 1'b1;
    end else begin
      tx_buf_s = tx_buf_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      shift_out_r  <= ZERO_WORD;
      shift_in_r   <= ZERO_WORD[SPI_TRF_BIT-2:0];
      bit_cnt_r    <= {CNT_W{1'b0}};
      miso_r       <= 1'b0;
      rx_data_r    <= ZERO_WORD;
      rx_valid_r   <= 1'b0;
      frame_err_r  <= 1'b0;
      tx_buf_r     <= ZERO_WORD;
      tx_pending_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      shift_out_r  <= shift_out_s;
      shift_in_r   <= shift_in_s;
      bit_cnt_r    <= bit_cnt_s;
      miso_r       <= miso_s;
      rx_data_r    <= rx_data_s;
      rx_valid_r   <= rx_valid_s;
      frame_err_r  <= frame_err_s;
      tx_buf_r     <= tx_buf_s;
      tx_pending_r <= tx_pending_s;
      busy_r       <= (state_s != IDLE);
    end
  end

  assign miso       = miso_r;
  assign rx_data    = rx_data_r;
  assign rx_valid   = rx_valid_r;
  assign frame_err  = frame_err_r;
  assign tx_pending = tx_pending_r;
  assign busy       = busy_r;

endmodule
